// File: rtl/analog_io_pkg.sv
// -----------------------------------------------------------------------------
// analog_io_pkg
// Shared constants for the analog_io controller slice:
//   BITS_DEFAULT     default analog value width (matches the port block)
//   DIR_IN / DIR_OUT direction encodings driven onto the port block
//   state_t / ST_*   controller FSM state encoding
// -----------------------------------------------------------------------------
package analog_io_pkg;

   localparam int BITS_DEFAULT = 16;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   // FSM state encoding kept as plain constants so legacy tools that choke on
   // enum ports can still consume this package.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_WRITE  = 3'd1;
   localparam state_t ST_SETTLE = 3'd2;
   localparam state_t ST_SAMPLE = 3'd3;
   localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/analog_avg_acc.sv
// -----------------------------------------------------------------------------
// analog_avg_acc
// Accumulates 2^AVG_LOG2 samples and produces their truncated average.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     force accumulator and sample counter back to zero
//   acc_en    add 'sample' this cycle
//   sample    current analog input value
//   done      this cycle's sample is the last one of the set
//   result    (accumulator + sample) >> AVG_LOG2, valid when done is high
// The accumulator and counter clear themselves after the last sample, so the
// next read always starts from zero.
// -----------------------------------------------------------------------------
module analog_avg_acc
   import analog_io_pkg::*;
#(
   parameter int BITS     = BITS_DEFAULT,
   parameter int AVG_LOG2 = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            acc_en,
   input  logic [BITS-1:0] sample,
   output logic            done,
   output logic [BITS-1:0] result
);

   // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so it
   // never overflows. Counter gets one spare bit so AVG_LOG2=0 still works.
   localparam int ACC_W = BITS + AVG_LOG2;
   localparam int CNT_W = AVG_LOG2 + 1;
   localparam int NUM   = 1 << AVG_LOG2;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The result includes the sample presented on the last cycle, so the
   // average is available in the same cycle the final sample arrives.
   always_comb begin
      sum    = acc_q + ACC_W'(sample);
      done   = (cnt_q == CNT_W'(NUM - 1));
      result = sum[ACC_W-1:AVG_LOG2];
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      if (clear) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (acc_en) begin
         if (done) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/analog_io_ctrl.sv
// -----------------------------------------------------------------------------
// analog_io_ctrl
// Converts CPU read/write requests into enable/direction/data sequencing for
// one analog_io port block. Writes latch a value in one cycle; reads wait
// SETTLE cycles and then average 2^AVG_LOG2 samples.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_write/req_data   CPU request (accepted only in IDLE)
//   req_ready                      high only in IDLE
//   rsp_valid/rsp_ready/rsp_data   response: read average or write echo
//   io_en/io_dir/io_wdata          drive to the port block
//   io_rdata                       sampled value from the port block
// Build option:
//   ANALOG_IO_CTRL_CLAMP_EN  clamp write values to [OUT_MIN, OUT_MAX]
//                            (unsigned); otherwise write data passes through.
// -----------------------------------------------------------------------------
module analog_io_ctrl
   import analog_io_pkg::*;
#(
   parameter int              BITS     = BITS_DEFAULT,
   parameter int              AVG_LOG2 = 2,
   parameter int              SETTLE   = 4,
   parameter logic [BITS-1:0] OUT_MIN  = '0,
   parameter logic [BITS-1:0] OUT_MAX  = 16'hFFFF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   input  logic            req_write,
   input  logic [BITS-1:0] req_data,
   output logic            req_ready,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [BITS-1:0] rsp_data,
   output logic            io_en,
   output logic            io_dir,
   output logic [BITS-1:0] io_wdata,
   input  logic [BITS-1:0] io_rdata
);

   // Settle counter runs 0..SETTLE-1; at least one bit so SETTLE of 0 or 1
   // still elaborates.
   localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t            state_q, state_d;
   logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
   logic              io_en_q, io_en_d;
   logic              io_dir_q, io_dir_d;
   logic [BITS-1:0]   io_wdata_q, io_wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [BITS-1:0]   rsp_data_q, rsp_data_d;

   logic              acc_clear;
   logic              acc_en;
   logic              acc_done;
   logic [BITS-1:0]   acc_result;
   logic [BITS-1:0]   wr_val;

`ifdef ANALOG_IO_CTRL_CLAMP_EN
   // Unsigned clamp of the write value; both the port drive and the echo
   // carry the clamped value.
   always_comb begin
      if (req_data < OUT_MIN) begin
         wr_val = OUT_MIN;
      end else if (req_data > OUT_MAX) begin
         wr_val = OUT_MAX;
      end else begin
         wr_val = req_data;
      end
   end
`else
   // Pass-through build. The clamp bounds are folded into a sink so the
   // parameter list stays identical between builds.
   logic unused_clamp_bounds;
   assign unused_clamp_bounds = ^{OUT_MIN, OUT_MAX};
   assign wr_val = req_data;
`endif

   analog_avg_acc #(
      .BITS     (BITS),
      .AVG_LOG2 (AVG_LOG2)
   ) u_avg (
      .clk    (clk),
      .rst    (rst),
      .clear  (acc_clear),
      .acc_en (acc_en),
      .sample (io_rdata),
      .done   (acc_done),
      .result (acc_result)
   );

   // Main FSM. io_dir is deliberately left alone outside the accept cycle so
   // a written output keeps being driven until a read releases it.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      io_en_d      = io_en_q;
      io_dir_d     = io_dir_q;
      io_wdata_d   = io_wdata_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      acc_clear    = 1'b0;
      acc_en       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            acc_clear = 1'b1;
            if (req_valid) begin
               io_en_d = 1'b1;
               if (req_write) begin
                  io_dir_d   = DIR_OUT;
                  io_wdata_d = wr_val;
                  state_d    = ST_WRITE;
               end else begin
                  io_dir_d     = DIR_IN;
                  settle_cnt_d = '0;
                  state_d      = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
               end
            end
         end

         ST_WRITE: begin
            io_en_d     = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = io_wdata_q;
            state_d     = ST_DONE;
         end

         ST_SETTLE: begin
            if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
               settle_cnt_d = '0;
               state_d      = ST_SAMPLE;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end

         ST_SAMPLE: begin
            acc_en = 1'b1;
            if (acc_done) begin
               io_en_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = acc_result;
               state_d     = ST_DONE;
            end
         end

         ST_DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reset drops any in-flight transaction and releases the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         settle_cnt_q <= '0;
         io_en_q      <= 1'b0;
         io_dir_q     <= DIR_IN;
         io_wdata_q   <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         io_en_q      <= io_en_d;
         io_dir_q     <= io_dir_d;
         io_wdata_q   <= io_wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign io_en     = io_en_q;
   assign io_dir    = io_dir_q;
   assign io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_analog_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_analog_io_ctrl
// Directed bench for analog_io_ctrl (BITS=16, AVG_LOG2=2, SETTLE=4,
// OUT_MIN=16'h0010, OUT_MAX=16'h0FFF). Expected responses are queued when a
// request is issued and checked by an independent response monitor.
// Honours ANALOG_IO_CTRL_CLAMP_EN for the expected write values.
// -----------------------------------------------------------------------------
module tb_analog_io_ctrl;

`ifdef ANALOG_IO_CTRL_CLAMP_EN
   localparam logic [15:0] EXP_1234 = 16'h0FFF;
   localparam logic [15:0] EXP_0005 = 16'h0010;
   localparam logic [15:0] EXP_FFFF = 16'h0FFF;
`else
   localparam logic [15:0] EXP_1234 = 16'h1234;
   localparam logic [15:0] EXP_0005 = 16'h0005;
   localparam logic [15:0] EXP_FFFF = 16'hFFFF;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_data = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_data;
   logic        io_en;
   logic        io_dir;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata = '0;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] expQ[$];
   logic [15:0] rdSched [0:63];
   logic [15:0] monExp;

   int          lat;
   logic [31:0] enHist;
   logic [31:0] dirHist;
   logic [15:0] wd1;

   always #5 clk = ~clk;

   analog_io_ctrl #(
      .BITS     (16),
      .AVG_LOG2 (2),
      .SETTLE   (4),
      .OUT_MIN  (16'h0010),
      .OUT_MAX  (16'h0FFF)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .io_en     (io_en),
      .io_dir    (io_dir),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata)
   );

   // One comparison: count it, report it if it differs
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s: timed out waiting on DUT", name);
   endtask

   // Response monitor: every completed response handshake pops one entry
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_unexpected: got 0x%0h, wanted no response", rsp_data);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rsp_data", 32'(rsp_data), 32'(monExp));
         end
      end
   end

   // Issue one request, record io_en/io_dir per cycle after accept until
   // rsp_valid shows, optionally hold off rsp_ready for 'hold' cycles.
   task automatic applyStimulus(input logic wr, input logic [15:0] d, input logic [15:0] expRsp,
                                input int hold, output int latOut, output logic [31:0] enOut,
                                output logic [31:0] dirOut, output logic [15:0] wdOut);
      int  n;
      bit  seen;
      enOut  = '0;
      dirOut = '0;
      wdOut  = '0;
      latOut = 0;
      expQ.push_back(expRsp);
      if (hold > 0) rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = wr;
      req_data  = d;
      io_rdata  = rdSched[0];
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         reportTimeout("req_accept");
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         return;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      seen = 1'b0;
      while (!seen && n < 60) begin
         io_rdata = rdSched[n];
         @(negedge clk);
         enOut[n]  = io_en;
         dirOut[n] = io_dir;
         if (n == 1) wdOut = io_wdata;
         if (rsp_valid) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      if (!seen) begin
         reportTimeout("rsp_valid_wait");
         rsp_ready = 1'b1;
         return;
      end
      latOut = n;
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_data  = 16'h0BEE;
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("hold_rsp_data", 32'(rsp_data), 32'(expRsp));
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
         end
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         req_valid = 1'b0;
         @(negedge clk);
         checkOutput("hold_no_accept_en", 32'(io_en), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("idle_req_ready", 32'(req_ready), 32'd1);
      checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 64; i++) rdSched[i] = 16'h0000;

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("rst_io_en", 32'(io_en), 32'd0);
      checkOutput("rst_io_dir", 32'(io_dir), 32'd0);
      checkOutput("rst_io_wdata", 32'(io_wdata), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Write 16'h1234
      $display("[TB] write 0x1234");
      applyStimulus(1'b1, 16'h1234, EXP_1234, 0, lat, enHist, dirHist, wd1);
      checkOutput("wr_latency", 32'(lat), 32'd2);
      checkOutput("wr_en_pulse", 32'(enHist[2:1]), 32'b01);
      checkOutput("wr_dir", 32'(dirHist[2:1]), 32'b11);
      checkOutput("wr_wdata", 32'(wd1), 32'(EXP_1234));
      checkOutput("wr_dir_held", 32'(io_dir), 32'd1);

      // Read with a constant input
      $display("[TB] read constant 0x0100");
      for (int i = 0; i < 64; i++) rdSched[i] = 16'h0100;
      applyStimulus(1'b0, 16'h0000, 16'h0100, 0, lat, enHist, dirHist, wd1);
      checkOutput("rd_latency", 32'(lat), 32'd9);
      checkOutput("rd_en_window", 32'(enHist[9:1]), 32'h0FF);
      checkOutput("rd_dir", 32'(dirHist[9:1]), 32'h000);
      checkOutput("rd_dir_released", 32'(io_dir), 32'd0);

      // Read with varying samples; settle-time values must not count
      $display("[TB] read sequence 10,11,12,14");
      for (int i = 0; i < 64; i++) rdSched[i] = 16'hFFFF;
      rdSched[5] = 16'd10;
      rdSched[6] = 16'd11;
      rdSched[7] = 16'd12;
      rdSched[8] = 16'd14;
      applyStimulus(1'b0, 16'h0000, 16'd11, 0, lat, enHist, dirHist, wd1);
      checkOutput("rd_seq_latency", 32'(lat), 32'd9);

      // Write with a held-off response
      $display("[TB] write 0x0ABC with rsp_ready held low");
      applyStimulus(1'b1, 16'h0ABC, 16'h0ABC, 5, lat, enHist, dirHist, wd1);
      checkOutput("hold_wr_latency", 32'(lat), 32'd2);

      // Reset in the middle of SAMPLE
      $display("[TB] reset during sample");
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_write = 1'b0;
      io_rdata  = 16'hFFFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_io_en", 32'(io_en), 32'd0);
      checkOutput("midrst_io_dir", 32'(io_dir), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < 64; i++) rdSched[i] = 16'h0200;
      applyStimulus(1'b0, 16'h0000, 16'h0200, 0, lat, enHist, dirHist, wd1);
      checkOutput("midrst_rd_latency", 32'(lat), 32'd9);

      // Clamp boundaries (pass-through without the clamp build)
      $display("[TB] write clamp boundaries");
      applyStimulus(1'b1, 16'h0005, EXP_0005, 0, lat, enHist, dirHist, wd1);
      checkOutput("clamp_low_wdata", 32'(wd1), 32'(EXP_0005));
      applyStimulus(1'b1, 16'hFFFF, EXP_FFFF, 0, lat, enHist, dirHist, wd1);
      checkOutput("clamp_high_wdata", 32'(wd1), 32'(EXP_FFFF));

      repeat (3) @(posedge clk);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/analog_io_ctrl.md
Name: analog_io_ctrl

Overview:
Transaction-level controller that drives the analog_io port block from the PLC CPU side. It converts CPU read/write requests into the port block's enable, direction and data sequencing. Writes are one-cycle latch operations. Reads wait a settle time, then average 2^AVG_LOG2 samples. Sits between the CPU I/O bus and one analog_io instance.

Parameters:
BITS, 16, width of analog value (matches port block)
AVG_LOG2, 2, log2 of samples averaged per read (0 = single sample)
SETTLE, 4, cycles waited after switching to input before first sample (0 allowed)
OUT_MIN, 0, lower clamp bound for writes (used only with clamp feature)
OUT_MAX, 16'hFFFF, upper clamp bound for writes (used only with clamp feature)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  CPU request present
req_write  input  1  1 = write (set output), 0 = read (sample input)
req_data  input  BITS  value to output on write
req_ready  output  1  controller accepts request (IDLE only)
rsp_valid  output  1  response available
rsp_ready  input  1  CPU consumes response
rsp_data  output  BITS  read result, or written value echoed
io_en  output  1  to port block en
io_dir  output  1  to port block direction (1 = drive output)
io_wdata  output  BITS  to port block data_in
io_rdata  input  BITS  from port block data_out

Behaviour:
- Reset, also mid-operation: state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, io_en=0, io_dir=0 (port released), io_wdata=0, accumulator=0, counters=0. Any in-flight transaction is dropped with no response.
- Handshake: request accepted on a cycle with req_valid & req_ready. Response completes on a cycle with rsp_valid & rsp_ready. Until then rsp_valid and rsp_data hold stable. req_ready=0 in all states except IDLE, so there is no overlap of transactions.
- States: IDLE, WRITE, SETTLE, SAMPLE, DONE.
- IDLE + accepted write -> WRITE. The cycle after accept: io_dir=1, io_wdata=value, io_en=1 for exactly one cycle. Then DONE with rsp_data=value. io_dir stays 1 after the write so the port holds its output.
- IDLE + accepted read -> SETTLE. io_dir=0 from the cycle after accept, io_en=1 throughout SETTLE and SAMPLE.
- SETTLE lasts exactly SETTLE cycles. If SETTLE=0, go directly to SAMPLE.
- SAMPLE lasts 2^AVG_LOG2 cycles. Each cycle adds io_rdata to an accumulator of width BITS+AVG_LOG2, which cannot overflow. On exit, rsp_data = acc >> AVG_LOG2 (truncating), io_en=0, accumulator cleared, state DONE.
- DONE: rsp_valid=1 until rsp_ready, then IDLE on the next cycle.
- Read latency: accept to rsp_valid = 1 + SETTLE + 2^AVG_LOG2 cycles. Write latency: accept to rsp_valid = 2 cycles.
- A read leaves io_dir=0, so a previously written output is released. The next write re-drives it.
- req_valid asserted while not ready is ignored; the CPU must hold it.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
ANALOG_IO_CTRL_CLAMP_EN
- Defined: write value = min(max(req_data, OUT_MIN), OUT_MAX), unsigned compare. Both io_wdata and the rsp_data echo carry the clamped value.
- Undefined: req_data passes through unchanged; OUT_MIN and OUT_MAX are unused. Latency is identical in both builds.

Decomposition:
- Package analog_io_pkg: FSM state enum, default BITS constant, direction encodings DIR_IN=0 / DIR_OUT=1.
- One sub-module, analog_avg_acc: clear, accumulate, sample counter, done flag, shifted result. Parameterised by BITS and AVG_LOG2.
- FSM and handshake logic stay in analog_io_ctrl.

Test Plan:
- Reset, then write 16'h1234 -> io_en pulses 1 cycle with io_dir=1 and io_wdata=16'h1234. rsp_valid 2 cycles after accept, rsp_data=16'h1234, io_dir stays 1.
- Read with io_rdata fixed at 16'h0100, SETTLE=4, AVG_LOG2=2 -> rsp_valid exactly 9 cycles after accept, rsp_data=16'h0100, io_dir=0.
- Read with io_rdata sequence 10, 11, 12, 14 during SAMPLE -> rsp_data=11 (47>>2). Values presented during SETTLE do not affect the result.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_data stable, req_ready=0, a new req_valid is not accepted. After rsp_ready, IDLE on the next cycle.
- Assert rst in SAMPLE mid-read -> next cycle IDLE, io_en=0, io_dir=0, rsp_valid=0. A following read returns the correct average (accumulator was cleared).
- With ANALOG_IO_CTRL_CLAMP_EN, OUT_MIN=16'h0010, OUT_MAX=16'h0FFF: write 16'h0005 -> io_wdata=16'h0010; write 16'hFFFF -> io_wdata=16'h0FFF. Without the macro, both pass through unchanged.
